// File: rtl/led_afterglow.sv
// led_afterglow
//   Per-LED PWM driver with a fading trail. Every clock, a set pattern bit
//   loads that LED's brightness level from dim. Once the bit drops, the level
//   steps down by one on each decay tick until it reaches zero. Each level
//   drives a PWM output with a period of 2^BW clocks.
//
//   Optional build macro: LED_AFTERGLOW_GAMMA_EN
//     defined   : duty = (level*level) >> BW, for a perceptually linear fade
//     undefined : duty = level, for a linear duty fade
//
// Ports
//   clock      in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   pattern    in   NLED  LED on/off pattern, sampled every clock
//   enable     in   1 = drive LEDs, 0 = force led low (state keeps running)
//   decay_rate in   2     fade speed; prescaler step = decay_rate + 1
//   dim        in   BW    brightness loaded into a lit LED
//   led        out  NLED  registered PWM drive, active-high
//   pwm_sync   out  1     registered pulse at the start of each PWM period
module led_afterglow #(
  parameter int NLED      = 8,
  parameter int BW        = 4,
  parameter int DECAY_PRE = 18
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [NLED-1:0] pattern,
  input  logic            enable,
  input  logic [1:0]      decay_rate,
  input  logic [BW-1:0]   dim,
  output logic [NLED-1:0] led,
  output logic            pwm_sync
);

  logic [DECAY_PRE-1:0] r_pre;
  logic                 r_decay_tick;
  logic [BW-1:0]        r_pwm_cnt;
  logic                 r_pwm_sync;
  logic [NLED-1:0]      r_led;
  logic [NLED-1:0]      w_led_next;
  logic [DECAY_PRE:0]   w_pre_sum;

  // The prescaler is an accumulator. Its carry-out is the decay tick, so
  // every rate gives a fractional period without a divider.
  assign w_pre_sum = {1'b0, r_pre}
                   + {{(DECAY_PRE-1){1'b0}}, decay_rate}
                   + {{DECAY_PRE{1'b0}}, 1'b1};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pre        <= '0;
      r_decay_tick <= 1'b0;
      r_pwm_cnt    <= '0;
      r_pwm_sync   <= 1'b0;
      r_led        <= '0;
    end else begin
      r_pre        <= w_pre_sum[DECAY_PRE-1:0];
      r_decay_tick <= w_pre_sum[DECAY_PRE];
      r_pwm_cnt    <= r_pwm_cnt + 1'b1;
      r_pwm_sync   <= (r_pwm_cnt == '0);
      r_led        <= w_led_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NLED; gi++) begin : g_led
      logic [BW-1:0] r_level;
      logic [BW-1:0] w_duty;

      // A load has priority over a decay tick in the same cycle. Decay
      // saturates at zero.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          r_level <= '0;
        end else if (pattern[gi]) begin
          r_level <= dim;
        end else if (r_decay_tick && (r_level != '0)) begin
          r_level <= r_level - 1'b1;
        end
      end

`ifdef LED_AFTERGLOW_GAMMA_EN
      logic [2*BW-1:0] w_sq;
      assign w_sq   = {{BW{1'b0}}, r_level} * {{BW{1'b0}}, r_level};
      assign w_duty = BW'(w_sq >> BW);
`else
      assign w_duty = r_level;
`endif

      assign w_led_next[gi] = enable & (w_duty > r_pwm_cnt);
    end
  endgenerate

  assign led      = r_led;
  assign pwm_sync = r_pwm_sync;

endmodule

// File: tb/tb_led_afterglow.sv
// tb_led_afterglow
//   Randomised and directed stimulus for led_afterglow (NLED=8, BW=4,
//   DECAY_PRE=4). A reference model computes the expected led/pwm_sync for
//   every clock and queues it. An independent monitor pops each entry and
//   compares it against the DUT one time unit after the edge.
module tb_led_afterglow;

  localparam int NLED = 8;
  localparam int BW   = 4;
  localparam int PER  = 1 << BW;   // PWM period
  localparam int PRE  = 1 << 4;    // prescaler modulus for DECAY_PRE=4

  logic            clock = 1'b0;
  logic            reset_n;
  logic [NLED-1:0] pattern;
  logic            enable;
  logic [1:0]      decay_rate;
  logic [BW-1:0]   dim;
  logic [NLED-1:0] led;
  logic            pwm_sync;

  led_afterglow #(.NLED(NLED), .BW(BW), .DECAY_PRE(4)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .pattern    (pattern),
    .enable     (enable),
    .decay_rate (decay_rate),
    .dim        (dim),
    .led        (led),
    .pwm_sync   (pwm_sync)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [NLED-1:0] led;
    logic            sync;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Brightness-to-duty mapping, written from its arithmetic definition.
  function automatic int duty_of(int lvl);
`ifdef LED_AFTERGLOW_GAMMA_EN
    return (lvl * lvl) / PER;
`else
    return lvl;
`endif
  endfunction

  // Reference model. The state is kept as plain integers: the per-LED
  // brightness, the PWM position within the period, the accumulated decay
  // phase, and whether a decay step is due this cycle.
  int m_lvl[NLED];
  int m_pos;
  int m_phase;
  bit m_step_due;

  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      if (!reset_n) begin
        foreach (m_lvl[i]) m_lvl[i] = 0;
        m_pos = 0; m_phase = 0; m_step_due = 0;
        e.led = '0; e.sync = 1'b0;
      end else begin
        e.sync = (m_pos == 0);
        for (int i = 0; i < NLED; i++)
          e.led[i] = enable && (duty_of(m_lvl[i]) > m_pos);
        for (int i = 0; i < NLED; i++) begin
          if (pattern[i])                       m_lvl[i] = int'(dim);
          else if (m_step_due && m_lvl[i] > 0)  m_lvl[i] = m_lvl[i] - 1;
        end
        m_step_due = (m_phase + int'(decay_rate) + 1) >= PRE;
        m_phase    = (m_phase + int'(decay_rate) + 1) % PRE;
        m_pos      = (m_pos + 1) % PER;
      end
      exp_q.push_back(e);
    end
  end

  // Monitor: the outputs are valid every clock, so one entry is consumed per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty t=%0t", $time);
      end else begin
        e = exp_q.pop_front();
        if (led !== e.led || pwm_sync !== e.sync) begin
          errors++;
          $display("FAIL led_pwm t=%0t got led=%02h sync=%b expected led=%02h sync=%b",
                   $time, led, pwm_sync, e.led, e.sync);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic phase(input string name, input int n);
    step(n);
    $display("phase %-12s done t=%0t checks=%0d errors=%0d", name, $time, checks, errors);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; pattern = '0; enable = 1'b1; decay_rate = 2'd0; dim = '0;
    step(3);
    reset_n = 1'b1;

    // Steady brightness at full and at partial duty.
    dim = 4'd15; pattern = 8'h01;
    phase("steady15", 40);
    dim = 4'd4;
    phase("steady4", 40);

    // Full fade at the slowest and at the fastest rate.
    dim = 4'd15;
    step(3);
    pattern = 8'h00;
    phase("decay_r0", 16 * 17);
    pattern = 8'h01; decay_rate = 2'd3;
    step(3);
    pattern = 8'h00;
    phase("decay_r3", 80);

    // Toggle the load against running ticks, then a zero-brightness load.
    decay_rate = 2'd0; dim = 4'd5; pattern = 8'h01;
    step(2);
    pattern = 8'h00;
    for (int i = 0; i < 48; i++) begin
      step(1);
      dim     = (i % 4 == 0) ? 4'd9 : 4'd5;
      pattern = (i % 3 == 0) ? 8'h01 : 8'h00;
    end
    $display("phase %-12s done t=%0t checks=%0d errors=%0d", "load_vs_tick", $time, checks, errors);
    dim = 4'd0; pattern = 8'hFF;
    phase("dim0", 40);

    // Gate the output while the levels keep decaying.
    dim = 4'd15; pattern = 8'hFF;
    step(3);
    pattern = 8'h00; decay_rate = 2'd3; enable = 1'b0;
    step(12);
    enable = 1'b1;
    phase("enable_gate", 32);

    // Asynchronous reset in the middle of a glowing pattern.
    decay_rate = 2'd1; dim = 4'd15; pattern = 8'h81;
    step(20);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (led !== 8'h00 || pwm_sync !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got led=%02h sync=%b expected led=00 sync=0", led, pwm_sync);
    end
    step(2);
    reset_n = 1'b1;
    phase("async_reset", 40);

    // Randomised traffic with a moving eye, random rates, dims and gating.
    for (int i = 0; i < 1500; i++) begin
      step(1);
      case ($urandom_range(0, 9))
        0:       pattern = 8'($urandom);
        1, 2:    pattern = 8'h00;
        default: pattern = 8'(1 << $urandom_range(0, NLED - 1));
      endcase
      if ($urandom_range(0, 7) == 0) dim        = 4'($urandom);
      if ($urandom_range(0, 31) == 0) decay_rate = 2'($urandom);
      if ($urandom_range(0, 15) == 0) enable     = ($urandom_range(0, 3) != 0);
    end
    $display("phase %-12s done t=%0t checks=%0d errors=%0d", "random", $time, checks, errors);

    step(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
